keccak_core_arbiter: RTL and testbench

- Shares one Keccak hash core (start/done sequencing, L-bit message in, b-bit state out) between N requesters, e.g. parallel miner lanes.
- Grants requesters round-robin, latches the winner's message and pulses the core start.
- Waits for core completion with a timeout, then returns the final state tagged with the requester ID over a valid/ready handshake.

---
 rtl/keccak_core_arbiter.sv | 105 ++++++++++
 tb/tb_keccak_core_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_core_arbiter.sv
// keccak_core_arbiter: round-robin sharing of one Keccak core between N requesters,
// with launch, blanked done capture, timeout abort and valid/ready result return.
module keccak_core_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = 2,
  parameter int L       = 160,
  parameter int b       = 400,
  parameter int TIMEOUT = 255
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [N-1:0]   i_req,
  input  logic [N*L-1:0] i_v_data,
  output logic [N-1:0]   o_ack,
  output logic           o_core_start,
  output logic [L-1:0]   o_core_data,
  input  logic           i_core_done,
  input  logic [b-1:0]   i_core_state,
  output logic           o_valid,
  input  logic           i_rdy,
  output logic [b-1:0]   o_v_state,
  output logic [IDW-1:0] o_id,
  output logic           o_busy,
  output logic           o_timeout
);
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_OUTPUT} state_t;
  state_t         r_state;
  logic [IDW-1:0] r_ptr, r_id, w_sel, w_idx;
  logic [15:0]    r_cnt;
  logic [16:0]    w_cnt_inc;
  logic [N-1:0]   r_ack;
  logic [L-1:0]   r_core_data;
  logic [b-1:0]   r_v_state;
  logic           r_start, r_valid, r_busy, r_timeout;
  // reverse scan so the last hit is the first set bit at or after the pointer
  always_comb begin
    w_sel = '0;
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = IDW'((int'(r_ptr) + i) % N);
      if (i_req[w_idx]) w_sel = w_idx;
    end
  end
  assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_core_data <= '0;
      r_v_state   <= '0;
      r_start     <= 1'b0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_ack   <= '0;
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: if (|i_req) begin
          r_ack       <= N'(1) << w_sel;
          r_core_data <= i_v_data[w_sel*L +: L];
          r_id        <= w_sel;
          r_ptr       <= IDW'((int'(w_sel) + 1) % N);
          r_busy      <= 1'b1;
          r_state     <= S_LAUNCH;
        end
        S_LAUNCH: begin
          r_start <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          r_cnt <= w_cnt_inc[15:0];
          // done seen in the first busy cycle may be left over from the previous job
          if (i_core_done && r_cnt != 16'd0) begin
            r_v_state <= i_core_state;
            r_valid   <= 1'b1;
            r_state   <= S_OUTPUT;
          end else if (w_cnt_inc >= 17'(TIMEOUT)) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_OUTPUT: if (i_rdy) begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_ack        = r_ack;
  assign o_core_start = r_start;
  assign o_core_data  = r_core_data;
  assign o_valid      = r_valid;
  assign o_v_state    = r_v_state;
  assign o_id         = r_id;
  assign o_busy       = r_busy;
  assign o_timeout    = r_timeout;
endmodule

// File: tb/tb_keccak_core_arbiter.sv
// tb_keccak_core_arbiter: randomized jobs against a round-robin reference model,
// with a core model, a backpressuring consumer and a scoreboard monitor.
module tb_keccak_core_arbiter;
  localparam int N = 4, IDW = 2, L = 160, B = 400, TO = 24;
  localparam int M_PULSE = 0, M_LEVEL = 1, M_TMO = 2, M_HANG = 3;
  typedef struct {int id; logic [L-1:0] data; int mode; int d; bit bp;} job_t;
  typedef struct {int id; logic [B-1:0] st;} res_t;
  logic           clk, i_rst, i_core_done, i_rdy, o_core_start, o_valid, o_busy, o_timeout;
  logic [N-1:0]   i_req, o_ack;
  logic [N*L-1:0] i_v_data;
  logic [L-1:0]   o_core_data;
  logic [B-1:0]   i_core_state, o_v_state;
  logic [IDW-1:0] o_id;
  int errors = 0, checks = 0, ptr = 0, bp_req = 0;
  bit to_seen = 0;
  logic [N-1:0] ack_q[$];
  job_t job_q[$];
  res_t res_q[$];

  keccak_core_arbiter #(.N(N), .IDW(IDW), .L(L), .b(B), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_req(i_req), .i_v_data(i_v_data), .o_ack(o_ack),
    .o_core_start(o_core_start), .o_core_data(o_core_data), .i_core_done(i_core_done),
    .i_core_state(i_core_state), .o_valid(o_valid), .i_rdy(i_rdy), .o_v_state(o_v_state),
    .o_id(o_id), .o_busy(o_busy), .o_timeout(o_timeout));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [B-1:0] act, input logic [B-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [B-1:0] rnd();
    logic [B-1:0] v = '0;
    for (int i = 0; i < (B + 31) / 32; i++) v = {v[B-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic check_zero(input string ph);
    chk({ph, "_ack"}, B'(o_ack), '0);
    chk({ph, "_start"}, B'(o_core_start), '0);
    chk({ph, "_valid"}, B'(o_valid), '0);
    chk({ph, "_busy"}, B'(o_busy), '0);
    chk({ph, "_timeout"}, B'(o_timeout), '0);
    chk({ph, "_id"}, B'(o_id), '0);
    chk({ph, "_core_data"}, B'(o_core_data), '0);
    chk({ph, "_v_state"}, o_v_state, '0);
  endtask

  // Reference: grant the first requester at or after ptr, wrapping; ptr moves past it.
  task automatic issue(input logic [N-1:0] m, input int mode, input int d, input bit bp);
    logic [L-1:0] msg [N];
    int k = -1;
    bit got = 0;
    for (int i = 0; i < N; i++) begin
      msg[i] = L'(rnd());
      i_v_data[i*L +: L] = msg[i];
    end
    for (int i = 0; i < N; i++)
      if (k < 0 && m[(ptr + i) % N]) k = (ptr + i) % N;
    ptr = (k + 1) % N;
    ack_q.push_back(N'(1) << k);
    job_q.push_back('{k, msg[k], mode, d, bp});
    i_req = m;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      got = (o_ack != 0);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_wait: no ack within 400 cycles, required one of %b", m);
    end
    i_req = '0;
  endtask

  // Core model: optional stale level done into the first busy cycle, done at busy cycle d.
  initial begin
    job_t j;
    int lim;
    logic [B-1:0] st;
    i_core_done = 0;
    i_core_state = '0;
    forever begin
      @(negedge clk);
      if (i_rst) to_seen = 0;
      if (o_core_start && !i_rst) begin
        if (job_q.size() == 0) chk("unexpected_start", B'(o_core_start), '0);
        else begin
          j = job_q.pop_front();
          chk("core_data", B'(o_core_data), B'(j.data));
          chk("timeout_sticky", B'(o_timeout), B'(to_seen));
          if (j.mode == M_HANG) i_core_done = 0;
          lim = j.mode == M_HANG ? 1 : j.mode == M_TMO ? TO + 1 : j.d + 1;
          for (int c = 2; c <= lim; c++) begin
            @(negedge clk);
            if (j.mode == M_TMO) begin
              i_core_done = 0;
              if (c == TO) chk("busy_before_timeout", B'(o_busy), 1);
              if (c == TO + 1) begin
                chk("timeout_set", B'(o_timeout), 1);
                chk("timeout_no_valid", B'(o_valid), 0);
                chk("timeout_idle", B'(o_busy), 0);
                to_seen = 1;
              end
            end else if (c == j.d) begin
              st = rnd();
              i_core_done = 1;
              i_core_state = st;
              res_q.push_back('{j.id, st});
              if (j.bp) bp_req++;
            end else if (c == j.d + 1) begin
              chk("done_to_valid", B'(o_valid), 1);
              if (j.mode == M_PULSE) i_core_done = 0;
            end else i_core_done = 0;
          end
        end
      end
    end
  end

  // Consumer: mostly ready, holds off for 10 cycles when the core model asks.
  initial begin
    int hold = 0, seen = 0;
    i_rdy = 1;
    forever begin
      @(posedge clk);
      #1;
      if (seen != bp_req) begin
        seen = bp_req;
        hold = 10;
      end
      if (hold > 0) begin
        i_rdy = 0;
        hold--;
      end else i_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: grants, start timing, results and their stability under backpressure.
  initial begin
    logic [N-1:0] p_ack = '0;
    bit p_valid = 0, p_rdy = 0;
    res_t e;
    forever begin
      @(negedge clk);
      if (i_rst) begin
        p_ack = '0;
        p_valid = 0;
        p_rdy = 0;
        continue;
      end
      if (p_ack != 0) chk("ack_one_cycle", B'(o_ack), '0);
      else if (o_ack != 0) begin
        if (ack_q.size() == 0) chk("unexpected_ack", B'(o_ack), '0);
        else chk("ack", B'(o_ack), B'(ack_q.pop_front()));
      end
      if (o_core_start || p_ack != 0) chk("start_after_ack", B'(o_core_start), B'(p_ack != 0));
      if (o_valid) begin
        chk("quiet_while_valid", B'({o_ack, o_core_start}), '0);
        if (!p_valid) begin
          if (res_q.size() == 0) chk("unexpected_valid", B'(o_valid), '0);
          else begin
            e = res_q.pop_front();
            chk("result_id", B'(o_id), B'(e.id));
            chk("result_state", o_v_state, e.st);
          end
        end else begin
          chk("hold_id", B'(o_id), B'(e.id));
          chk("hold_state", o_v_state, e.st);
        end
      end
      if (p_valid && p_rdy) begin
        chk("valid_drop", B'(o_valid), 0);
        chk("idle_after_handshake", B'(o_busy), 0);
      end
      p_ack = o_ack;
      p_valid = o_valid;
      p_rdy = i_rdy;
    end
  end

  initial begin
    bit done = 0;
    i_rst = 0;
    i_req = '0;
    i_v_data = '0;
    #1 i_rst = 1;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    i_rst = 0;
    issue(4'b0100, M_PULSE, 20, 0);
    repeat (6) issue(4'b1111, $urandom_range(0, 1), $urandom_range(2, 12), 0);
    issue(4'b0011, M_PULSE, 5, 1);
    issue(4'b1000, M_LEVEL, 6, 0);
    issue(4'b0110, M_LEVEL, 15, 0);
    issue(4'b1001, M_PULSE, 2, 0);
    issue(4'b0101, M_PULSE, TO, 0);
    issue(4'b0010, M_TMO, 0, 0);
    issue(4'b0100, M_PULSE, 4, 0);
    for (int i = 0; i < 20; i++)
      issue(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 9) == 0 ? M_TMO : $urandom_range(0, 1),
            $urandom_range(2, TO), $urandom_range(0, 4) == 0);
    issue(4'b1111, M_HANG, 0, 0);
    repeat (4) @(negedge clk);
    #2 i_rst = 1;
    #1 check_zero("async_reset");
    ptr = 0;
    @(negedge clk);
    @(negedge clk);
    i_rst = 0;
    issue(4'b1010, M_PULSE, 5, 0);
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      done = res_q.size() == 0 && job_q.size() == 0 && !o_busy && !o_valid;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain: outstanding results=%0d busy=%0b, required 0 and 0", res_q.size(), o_busy);
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
